// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, monitor states, error codes and the legal-successor rule.
package traffic_pkg;
  localparam logic [3:0] CAR_RED  = 4'b1000;
  localparam logic [3:0] CAR_YEL  = 4'b0100;
  localparam logic [3:0] CAR_GRN  = 4'b0010;
  localparam logic [3:0] CAR_LEFT = 4'b0001;
  localparam logic [1:0] W_RED = 2'b10;
  localparam logic [1:0] W_GRN = 2'b01;
  localparam logic [1:0] W_OFF = 2'b00;
  localparam logic [1:0] W_BAD = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_TRACK, S_FAULT} state_t;
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ENC      = 3'd1;
  localparam logic [2:0] ERR_TRANS    = 3'd2;
  localparam logic [2:0] ERR_CONFLICT = 3'd3;
  localparam logic [2:0] ERR_SHORT    = 3'd4;
  localparam logic [2:0] ERR_LONG     = 3'd5;
  function automatic logic car_valid(input logic [3:0] c);
    return (c != 4'b0000) && ((c & (c - 4'd1)) == 4'b0000);
  endfunction
  function automatic logic legal_succ(input logic [3:0] from, input logic [3:0] to);
    return (from == CAR_GRN  && (to == CAR_YEL || to == CAR_LEFT)) ||
           (from == CAR_LEFT && to == CAR_YEL) ||
           (from == CAR_YEL  && to == CAR_RED) ||
           (from == CAR_RED  && to == CAR_GRN);
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating phase duration counter with a one-shot pulse on reaching the limit.
module phase_timer #(
  parameter int CNT_W     = 16,
  parameter int MAX_PHASE = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_hit
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_PHASE);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : (en && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    o_hit = en && !clr && cnt_q == MAX - 1'b1;
  end
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_cnt = cnt_q;
endmodule

// File: rtl/traffic_phase_monitor.sv
// traffic_phase_monitor: decodes and times controller light phases, flagging illegal behaviour.
module traffic_phase_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MIN_YELLOW = 3,
  parameter int MIN_GREEN  = 5,
  parameter int MAX_PHASE  = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [3:0]       i_car_traffic,
  input  logic [1:0]       i_walker_traffic,
  input  logic             i_clr,
  output logic             o_synced,
  output logic             o_phase_done,
  output logic [3:0]       o_last_phase,
  output logic [CNT_W-1:0] o_last_len,
  output logic [7:0]       o_cycle_cnt,
  output logic             o_err,
  output logic [2:0]       o_err_code,
  output logic [7:0]       o_err_cnt,
  output logic             o_fault
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_PHASE);
  state_t           state_q, state_d;
  logic [3:0]       car_q, car_d, prev_q, prev_d, last_phase_q, last_phase_d;
  logic [1:0]       walk_q, walk_d;
  logic [CNT_W-1:0] last_len_q, last_len_d, cnt, len;
  logic [7:0]       cycle_q, cycle_d, err_cnt_q, err_cnt_d;
  logic [2:0]       err_code_q, err_code_d, code;
  logic             synced_q, synced_d, done_q, done_d, err_q, err_d, fault_q, fault_d;
  logic             trk, chg, end_ph, clr, fatal, err_any, hit, t_clr, t_en;
  logic             e_enc, e_conf, e_trans, e_short;
  phase_timer #(.CNT_W(CNT_W), .MAX_PHASE(MAX_PHASE)) u_timer (
    .clk(clk), .reset(reset), .clr(t_clr), .en(t_en), .o_cnt(cnt), .o_hit(hit)
  );
  always_comb begin
    trk     = i_enable && state_q == S_TRACK;
    clr     = i_enable && i_clr;
    chg     = car_q != prev_q;
    len     = (cnt == MAX) ? MAX : cnt + 1'b1;
    end_ph  = trk && chg && car_valid(car_q) && car_valid(prev_q);
    e_enc   = trk && (!car_valid(car_q) || walk_q == W_BAD);
    e_conf  = trk && walk_q == W_GRN && car_q != CAR_RED;
    e_trans = trk && chg && !legal_succ(prev_q, car_q);
    e_short = end_ph && ((prev_q == CAR_YEL && len < CNT_W'(MIN_YELLOW)) ||
                         (prev_q == CAR_GRN && len < CNT_W'(MIN_GREEN)));
    code    = e_enc ? ERR_ENC : e_conf ? ERR_CONFLICT : e_trans ? ERR_TRANS :
              e_short ? ERR_SHORT : hit ? ERR_LONG : ERR_NONE;
    err_any = code != ERR_NONE && !clr;
    fatal   = (e_enc || e_conf) && !clr;
    t_en    = trk;
    t_clr   = (trk && chg) || (i_enable && state_q == S_SYNC && car_q == CAR_RED);
    car_d   = i_enable ? i_car_traffic : car_q;
    walk_d  = i_enable ? i_walker_traffic : walk_q;
    prev_d  = i_enable ? car_q : prev_q;
    state_d = !i_enable ? state_q :
              state_q == S_IDLE  ? S_SYNC :
              state_q == S_SYNC  ? (car_q == CAR_RED ? S_TRACK : S_SYNC) :
              state_q == S_TRACK ? (fatal ? S_FAULT : S_TRACK) :
              (clr ? S_SYNC : S_FAULT);
    done_d       = end_ph;
    last_phase_d = end_ph ? prev_q : last_phase_q;
    last_len_d   = end_ph ? len : last_len_q;
    cycle_d      = (end_ph && prev_q == CAR_RED && car_q == CAR_GRN && cycle_q != 8'hFF) ?
                   cycle_q + 8'd1 : cycle_q;
    err_d        = err_any;
    err_code_d   = clr ? ERR_NONE : err_any ? code : err_code_q;
    err_cnt_d    = clr ? 8'd0 : (err_any && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    fault_d      = state_d == S_FAULT;
    synced_d     = state_d == S_TRACK || state_d == S_FAULT;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q      <= S_IDLE;
      car_q        <= CAR_RED;
      walk_q       <= W_RED;
      prev_q       <= CAR_RED;
      last_phase_q <= '0;
      last_len_q   <= '0;
      cycle_q      <= '0;
      err_code_q   <= '0;
      err_cnt_q    <= '0;
      synced_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      car_q        <= car_d;
      walk_q       <= walk_d;
      prev_q       <= prev_d;
      last_phase_q <= last_phase_d;
      last_len_q   <= last_len_d;
      cycle_q      <= cycle_d;
      err_code_q   <= err_code_d;
      err_cnt_q    <= err_cnt_d;
      synced_q     <= synced_d;
      done_q       <= done_d;
      err_q        <= err_d;
      fault_q      <= fault_d;
    end
  assign o_synced     = synced_q;
  assign o_phase_done = done_q;
  assign o_last_phase = last_phase_q;
  assign o_last_len   = last_len_q;
  assign o_cycle_cnt  = cycle_q;
  assign o_err        = err_q;
  assign o_err_code   = err_code_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_fault      = fault_q;
endmodule
